// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_pkg
// Brief    : Shared sizing, FSM encoding and twiddle-table generator for the
//            butterfly feeder.
// Revision : 1.0
// ============================================================================
package ntt_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int N_COEFF    = 256;
    localparam int NUM_GROUPS = N_COEFF / 4;
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    // Twiddles are successive powers of a root of unity modulo the NTT prime
    localparam logic [63:0] ZETA_MOD  = 64'd8380417;
    localparam logic [63:0] ZETA_ROOT = 64'd1753;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [63:0] zeta_init(input int idx);
        logic [63:0] acc;
        acc = 64'd1;
        for (int k = 0; k < idx; k++) begin
            acc = (acc * ZETA_ROOT) % ZETA_MOD;
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_zeta_rom.sv
`default_nettype none
// ============================================================================
// Module   : ntt_zeta_rom
// Brief    : Combinational twiddle table, one entry per coefficient group.
// Revision : 1.0
// ============================================================================
module ntt_zeta_rom #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_GROUPS = 64,
    parameter int ADDR_W     = 6
) (
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_WIDTH-1:0] o_zeta
);
    import ntt_pkg::zeta_init;

    localparam int c_rom_depth = 1 << ADDR_W;

    logic [DATA_WIDTH-1:0] w_table [c_rom_depth];

    // Pad the table to a power of two so any address decodes to a defined value
    generate
        for (genvar gi = 0; gi < c_rom_depth; gi++) begin : g_rom
            if (gi < NUM_GROUPS) begin : g_used
                localparam logic [63:0] c_val = zeta_init(gi);
                assign w_table[gi] = DATA_WIDTH'(c_val);
            end else begin : g_pad
                assign w_table[gi] = '0;
            end
        end
    endgenerate

    assign o_zeta = w_table[i_addr];

endmodule
`default_nettype wire

// File: rtl/bu_feeder.sv
`default_nettype none
// ============================================================================
// Module   : bu_feeder
// Brief    : Packs a coefficient stream into 4-beat groups plus twiddle for
//            the butterfly stage.
// Revision : 1.0
// ============================================================================
module bu_feeder #(
    parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
    parameter int N_COEFF    = ntt_pkg::N_COEFF
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   coef_i,
    input  logic                    coef_valid_i,
    output logic                    coef_ready_o,
    output logic [2*DATA_WIDTH-1:0] data1_o,
    output logic [2*DATA_WIDTH-1:0] data2_o,
    output logic [DATA_WIDTH-1:0]   zeta_o,
    output logic                    valid_o,
    output logic                    busy_o,
    output logic                    done_o
);
    import ntt_pkg::*;

    localparam int                 c_num_groups = N_COEFF / 4;
    localparam int                 c_grp_w      = (c_num_groups > 1) ? $clog2(c_num_groups) : 1;
    localparam logic [c_grp_w-1:0] c_last_grp   = c_grp_w'(c_num_groups - 1);

    state_t                  r_state;
    logic [1:0]              r_beat;
    logic [c_grp_w-1:0]      r_grp;
    logic [DATA_WIDTH-1:0]   r_c0;
    logic [DATA_WIDTH-1:0]   r_c1;
    logic [DATA_WIDTH-1:0]   r_c2;
    logic [2*DATA_WIDTH-1:0] r_data1;
    logic [2*DATA_WIDTH-1:0] r_data2;
    logic [DATA_WIDTH-1:0]   r_zeta;
    logic                    r_valid;
    logic [DATA_WIDTH-1:0]   w_zeta;
    logic                    w_accept;

    ntt_zeta_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_GROUPS (c_num_groups),
        .ADDR_W     (c_grp_w)
    ) u_zeta_rom (
        .i_addr (r_grp),
        .o_zeta (w_zeta)
    );

    assign w_accept = coef_valid_i && (r_state == ST_FILL);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
            r_beat  <= 2'd0;
            r_grp   <= '0;
            r_c0    <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
            r_zeta  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_FILL;
                        r_beat  <= 2'd0;
                        r_grp   <= '0;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_beat <= r_beat + 2'd1;
                        case (r_beat)
                            2'd0: r_c0 <= coef_i;
                            2'd1: r_c1 <= coef_i;
                            2'd2: r_c2 <= coef_i;
                            2'd3: begin
                                // Final beat goes straight into the output pair
                                r_data1 <= {r_c1, r_c0};
                                r_data2 <= {coef_i, r_c2};
                                r_zeta  <= w_zeta;
                                r_valid <= 1'b1;
                                r_grp   <= r_grp + 1'b1;
                                if (r_grp == c_last_grp) begin
                                    r_state <= ST_DONE;
                                end
                            end
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign coef_ready_o = (r_state == ST_FILL);
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DONE);
    assign valid_o      = r_valid;
    assign data1_o      = r_data1;
    assign data2_o      = r_data2;
    assign zeta_o       = r_zeta;

endmodule
`default_nettype wire

// File: tb/tb_bu_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bu_feeder
// Brief    : Self-checking bench for bu_feeder (8- and 256-coefficient frames).
// Revision : 1.0
// ============================================================================
module tb_bu_feeder;

    localparam longint unsigned c_q    = 64'd8380417;
    localparam longint unsigned c_root = 64'd1753;

    typedef struct {
        bit          active;
        bit          finishing;
        int          beats;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [31:0] b2;
        bit          valid;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [31:0] zeta;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, cv_a, start_b, cv_b;
    logic [31:0] coef_a, coef_b;
    logic        ready_a, valid_a, busy_a, done_a;
    logic        ready_b, valid_b, busy_b, done_b;
    logic [63:0] d1_a, d2_a, d1_b, d2_b;
    logic [31:0] z_a, z_b;

    bu_feeder #(.DATA_WIDTH(32), .N_COEFF(8)) dut_a (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start_a), .coef_i(coef_a),
        .coef_valid_i(cv_a), .coef_ready_o(ready_a), .data1_o(d1_a),
        .data2_o(d2_a), .zeta_o(z_a), .valid_o(valid_a), .busy_o(busy_a),
        .done_o(done_a)
    );

    bu_feeder #(.DATA_WIDTH(32), .N_COEFF(256)) dut_b (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start_b), .coef_i(coef_b),
        .coef_valid_i(cv_b), .coef_ready_o(ready_b), .data1_o(d1_b),
        .data2_o(d2_b), .zeta_o(z_b), .valid_o(valid_b), .busy_o(busy_b),
        .done_o(done_b)
    );

    int          checks  = 0;
    int          passed  = 0;
    int          cyc     = 0;
    bit          chk_en  = 1'b0;
    int          nstrobe = 0;
    int          strobe_cyc [64];
    logic [31:0] strobe_z   [64];
    mdl_t        ma, mb;

    // Twiddle k = root^k mod q, by square-and-multiply
    function automatic logic [31:0] ref_zeta(input int k);
        longint unsigned base, acc, e;
        base = c_root;
        acc  = 1;
        e    = longint'(k);
        while (e > 0) begin
            if (e[0]) acc = (acc * base) % c_q;
            base = (base * base) % c_q;
            e    = e >> 1;
        end
        return acc[31:0];
    endfunction

    // Frame-level view: count beats of the frame, emit a group on every 4th
    function automatic mdl_t mstep(input mdl_t m, input int n, input bit rstn,
                                   input bit st, input bit cv, input logic [31:0] c);
        mdl_t r;
        r = m;
        if (!rstn) begin
            r = '{default: 0};
            return r;
        end
        r.valid = 1'b0;
        if (m.finishing) begin
            r.finishing = 1'b0;
        end else if (m.active) begin
            if (cv) begin
                case (m.beats % 4)
                    0: r.b0 = c;
                    1: r.b1 = c;
                    2: r.b2 = c;
                    default: begin
                        r.valid = 1'b1;
                        r.d1    = {m.b1, m.b0};
                        r.d2    = {c, m.b2};
                        r.zeta  = ref_zeta(m.beats / 4);
                    end
                endcase
                r.beats = m.beats + 1;
                if (r.beats == n) begin
                    r.active    = 1'b0;
                    r.finishing = 1'b1;
                end
            end
        end else if (st) begin
            r.active = 1'b1;
            r.beats  = 0;
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else passed++;
    endtask

    task automatic cmp_side(input string s, input mdl_t m, input logic rdy, input logic bsy,
                            input logic dn, input logic vld, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [31:0] z);
        check({s, "_ready"}, 64'(rdy), 64'(m.active));
        check({s, "_busy"},  64'(bsy), 64'(m.active | m.finishing));
        check({s, "_done"},  64'(dn),  64'(m.finishing));
        check({s, "_valid"}, 64'(vld), 64'(m.valid));
        check({s, "_data1"}, d1, m.d1);
        check({s, "_data2"}, d2, m.d2);
        check({s, "_zeta"},  64'(z), 64'(m.zeta));
    endtask

    always @(posedge clk) begin
        cyc++;
        ma = mstep(ma, 8,   rst_n, start_a, cv_a, coef_a);
        mb = mstep(mb, 256, rst_n, start_b, cv_b, coef_b);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_side("a", ma, ready_a, busy_a, done_a, valid_a, d1_a, d2_a, z_a);
            cmp_side("b", mb, ready_b, busy_b, done_b, valid_b, d1_b, d2_b, z_b);
            if (valid_b) begin
                if (nstrobe < 64) begin
                    strobe_cyc[nstrobe] = cyc;
                    strobe_z[nstrobe]   = z_b;
                end
                nstrobe++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        ma = '{default: 0};
        mb = '{default: 0};
        rst_n = 1'b1;
        start_a = 1'b0; cv_a = 1'b0; coef_a = '0;
        start_b = 1'b0; cv_b = 1'b0; coef_b = '0;
        #2 rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_ready", 64'(ready_a), 0);
        check("rst_busy",  64'(busy_a),  0);
        check("rst_valid", 64'(valid_a), 0);
        check("rst_data1", d1_a, 0);
        check("rst_zeta",  64'(z_a), 0);
        rst_n = 1'b1;
        tick();

        // Beats offered while idle are refused
        cv_a = 1'b1; coef_a = 32'd99;
        tick(); tick();
        check("idle_ready", 64'(ready_a), 0);
        check("idle_valid", 64'(valid_a), 0);
        cv_a = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("start_busy",  64'(busy_a),  1);
        check("start_ready", 64'(ready_a), 1);

        for (int i = 1; i <= 4; i++) begin
            cv_a = 1'b1; coef_a = 32'(i);
            tick();
        end
        check("g0_valid", 64'(valid_a), 1);
        check("g0_data1", d1_a, {32'd2, 32'd1});
        check("g0_data2", d2_a, {32'd4, 32'd3});
        check("g0_zeta",  64'(z_a), 1);
        check("g0_done",  64'(done_a), 0);

        for (int i = 5; i <= 8; i++) begin
            cv_a = 1'b1; coef_a = 32'(i); start_a = (i == 6);
            tick();
        end
        start_a = 1'b0; cv_a = 1'b0;
        check("g1_valid", 64'(valid_a), 1);
        check("g1_data1", d1_a, {32'd6, 32'd5});
        check("g1_data2", d2_a, {32'd8, 32'd7});
        check("g1_zeta",  64'(z_a), 1753);
        check("g1_done",  64'(done_a), 1);
        tick();
        check("end_busy",   64'(busy_a),  0);
        check("end_valid",  64'(valid_a), 0);
        check("hold_data1", d1_a, {32'd6, 32'd5});

        // Gapped beats: same group contents, later strobe
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            cv_a   = (i % 2 == 0);
            coef_a = (i % 2 == 0) ? 32'(21 + i / 2) : 32'hDEAD;
            tick();
        end
        check("gap_valid", 64'(valid_a), 1);
        check("gap_data1", d1_a, {32'd22, 32'd21});
        check("gap_data2", d2_a, {32'd24, 32'd23});
        check("gap_zeta",  64'(z_a), 1);
        for (int i = 0; i < 4; i++) begin
            cv_a = 1'b1; coef_a = 32'(25 + i);
            tick();
        end
        cv_a = 1'b0;
        check("gap_done",   64'(done_a), 1);
        check("gap1_data1", d1_a, {32'd26, 32'd25});
        tick();

        // Reset with a partial group pending
        start_a = 1'b1;
        tick();
        start_a = 1'b0; cv_a = 1'b1; coef_a = 32'd31;
        tick();
        coef_a = 32'd32;
        tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_ready", 64'(ready_a), 0);
        check("rstmid_busy",  64'(busy_a),  0);
        tick();
        rst_n = 1'b1; coef_a = 32'd33;
        tick(); tick(); tick();
        check("post_valid", 64'(valid_a), 0);
        check("post_busy",  64'(busy_a),  0);
        cv_a = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 9; i <= 12; i++) begin
            cv_a = 1'b1; coef_a = 32'(i);
            tick();
        end
        check("rs_valid", 64'(valid_a), 1);
        check("rs_data1", d1_a, {32'd10, 32'd9});
        check("rs_data2", d2_a, {32'd12, 32'd11});
        check("rs_zeta",  64'(z_a), 1);
        for (int i = 13; i <= 16; i++) begin
            coef_a = 32'(i);
            tick();
        end
        cv_a = 1'b0;
        check("rs_done", 64'(done_a), 1);
        tick();

        // Full 256-coefficient frame at one beat per cycle
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cv_b = 1'b1; coef_b = 32'(i * 5 + 7);
            tick();
        end
        cv_b = 1'b0;
        check("b_last_valid", 64'(valid_b), 1);
        check("b_last_done",  64'(done_b), 1);
        check("b_last_data1", d1_b, {32'd1272, 32'd1267});
        tick(); tick();
        check("b_busy_end", 64'(busy_b), 0);
        check("b_strobes",  64'(nstrobe), 64);
        bad = 0;
        for (int k = 1; k < 64; k++) begin
            if (strobe_cyc[k] - strobe_cyc[k-1] != 4) bad++;
        end
        check("b_spacing", 64'(bad), 0);
        check("b_z0", 64'(strobe_z[0]), 1);
        check("b_z1", 64'(strobe_z[1]), 1753);
        check("b_z2", 64'(strobe_z[2]), 3073009);
        check("b_z3", 64'(strobe_z[3]), 6757063);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bu_feeder.md
BU_FEEDER -- requirements
Module: bu_feeder

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, the width of one coefficient and one zeta.
REQ-002 The block SHALL take parameter N_COEFF, default 256, the coefficients per frame, a multiple of 4.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_ni, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port start_i, input, 1 bit, a frame start request.
REQ-006 The block SHALL have port coef_i, input, DATA_WIDTH, one coefficient per beat.
REQ-007 The block SHALL have port coef_valid_i, input, 1 bit, meaning coef_i is valid.
REQ-008 The block SHALL have port coef_ready_o, output, 1 bit, meaning the block accepts a beat.
REQ-009 The block SHALL have port data1_o, output, 2*DATA_WIDTH, the first coefficient pair for the butterfly stage.
REQ-010 The block SHALL have port data2_o, output, 2*DATA_WIDTH, the second coefficient pair for the butterfly stage.
REQ-011 The block SHALL have port zeta_o, output, DATA_WIDTH, the twiddle factor for the current group.
REQ-012 The block SHALL have port valid_o, output, 1 bit, a one-cycle strobe marking data1_o, data2_o and zeta_o as new.
REQ-013 The block SHALL have ports busy_o and done_o, output, 1 bit each: busy_o marks a frame in progress; done_o is a one-cycle end-of-frame pulse.

Function
REQ-014 The state machine SHALL have states IDLE, FILL and DONE.
REQ-015 In IDLE, start_i=1 SHALL move the block to FILL and clear the beat counter (2 bits) and the group counter (log2(N_COEFF/4) bits).
REQ-016 coef_ready_o SHALL be 1 only in FILL; a beat is accepted when coef_valid_i=1 and coef_ready_o=1 in the same cycle.
REQ-017 Accepted beats 0..2 of a group SHALL be stored as c0..c2; the beat counter SHALL increment on each accepted beat and wrap from 3 to 0.
REQ-018 On the accepted beat 3, the next rising edge SHALL register data1_o={c1,c0} and data2_o={c3,c2} (c3=coef_i, high half = higher index), load zeta_o from the zeta table at the current group index, and drive valid_o=1 for exactly one cycle.
REQ-019 Latency SHALL be one cycle from acceptance of beat 3 to valid_o.
REQ-020 Sustained throughput SHALL be one beat per cycle, which gives one group every 4 cycles, with no bubble between groups.
REQ-021 The group counter SHALL increment on each emitted group.
REQ-022 When the last group (N_COEFF/4-1) is accepted, the block SHALL enter DONE, with that group's valid_o appearing in the DONE cycle.
REQ-023 DONE SHALL assert done_o for one cycle and return to IDLE on the next edge.
REQ-024 busy_o SHALL equal (state != IDLE).
REQ-025 start_i while busy_o=1 SHALL be ignored, as SHALL coef_valid_i in IDLE or DONE.
REQ-026 Idle gaps of coef_valid_i=0 inside a frame SHALL stall assembly without loss and without changing the counters.
REQ-027 data1_o, data2_o and zeta_o SHALL hold their last values between valid_o strobes.

Reset
REQ-028 reset_ni=0 SHALL immediately force state IDLE, both counters to 0, c0..c2 to 0, and all outputs to 0, including coef_ready_o, valid_o, busy_o and done_o.
REQ-029 Reset mid-frame SHALL discard the partial group, and no valid_o SHALL follow release of reset until a new start_i.

Structure
REQ-030 Package ntt_pkg SHALL hold DATA_WIDTH, N_COEFF, the derived NUM_GROUPS=N_COEFF/4 and its counter width, and the state enum.
REQ-031 The zeta table SHALL be a sub-module ntt_zeta_rom: combinational, NUM_GROUPS entries of DATA_WIDTH, indexed by group number, with contents from an init file.
REQ-032 The block SHALL feed the butterfly top directly: data1_o, data2_o and zeta_o connect to its data1_i, data2_i and zeta_i.

Verification
REQ-033 Scenario: with N_COEFF=8, start, then beats 1,2,3,4 back-to-back -> one cycle after beat 4, valid_o=1, data1_o={2,1}, data2_o={4,3}, zeta_o=rom[0].
REQ-034 Scenario: continue with beats 5..8 -> valid_o with data1_o={6,5}, data2_o={8,7}, zeta_o=rom[1] in the same cycle as done_o=1; busy_o=0 on the next cycle.
REQ-035 Scenario: beats with coef_valid_i toggling 1,0,1,0 -> identical output values, valid_o delayed by the gaps only.
REQ-036 Scenario: start_i pulsed mid-frame -> counters unaffected; coef_valid_i in IDLE -> coef_ready_o=0 and no valid_o.
REQ-037 Scenario: reset_ni=0 after beat 2 of a group, then a restart with beats 9..12 -> first valid_o has data1_o={10,9}, data2_o={12,11}, zeta_o=rom[0].
REQ-038 Scenario: a full N_COEFF=256 frame at one beat per cycle -> 64 valid_o strobes exactly 4 cycles apart, and zeta_o of strobe k equals rom[k].
